// File: rtl/pbvi_converge_check.sv
// pbvi_converge_check
//   Convergence judge for the PBVI loop. A start pulse snapshots the selected alpha
//   vectors, actions and eps. The snapshot is compared one element per cycle against
//   the committed set, and the largest absolute difference is tracked. After the scan
//   the new set is committed. The block then requests another iteration (next_en),
//   stops with converged, or stops with timeout once the iteration cap is reached.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         loop-enable pulse; honoured only in idle
//   clear         synchronous; forgets history (committed vectors are kept)
//   eps           convergence threshold, sampled at start
//   alpha_in      N_POINTS x N_STATES x W; element e = point*N_STATES+comp at [e*W +: W]
//   action_in     2 bits per point
//   alpha_prev    committed alpha set
//   policy        committed actions
//   busy          high from the start edge until the judging edge
//   done          one-cycle pulse when an iteration is judged
//   next_en       one-cycle pulse with done when another iteration is wanted
//   converged     sticky terminal flag
//   timeout       sticky terminal flag
//   max_diff      largest |new-old| of the last judged iteration
//   iter_count    number of judged iterations since reset/clear
module pbvi_converge_check #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned N_STATES = 2,
  parameter int unsigned W        = 16,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned IW       = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           clear,
  input  logic [W-1:0]                   eps,
  input  logic [N_POINTS*N_STATES*W-1:0] alpha_in,
  input  logic [2*N_POINTS-1:0]          action_in,
  output logic [N_POINTS*N_STATES*W-1:0] alpha_prev,
  output logic [2*N_POINTS-1:0]          policy,
  output logic                           busy,
  output logic                           done,
  output logic                           next_en,
  output logic                           converged,
  output logic                           timeout,
  output logic [W-1:0]                   max_diff,
  output logic [IW-1:0]                  iter_count
);

  localparam int unsigned NElem = N_POINTS * N_STATES;
  localparam int unsigned IdxW  = (NElem > 1) ? $clog2(NElem) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NElem - 1);
  localparam logic [IW-1:0]   MaxIter = IW'(MAX_ITER);

  typedef enum logic [1:0] {StIdle, StScan, StDecide, StHalt} state_e;

  state_e                           state_q;
  logic [N_POINTS*N_STATES*W-1:0]   shadow_alpha_q;
  logic [2*N_POINTS-1:0]            shadow_act_q;
  logic [W-1:0]                     shadow_eps_q;
  logic [W-1:0]                     run_max_q;
  logic [IdxW-1:0]                  idx_q;
  logic                             prev_valid_q;

  logic [W-1:0]  cur_new, cur_old, diff, run_max_next;
  logic [IW-1:0] iter_next;

  // Absolute difference of the element under scan; ordered subtraction avoids wrap.
  always_comb begin
    cur_new      = shadow_alpha_q[32'(idx_q) * W +: W];
    cur_old      = alpha_prev[32'(idx_q) * W +: W];
    diff         = (cur_new > cur_old) ? (cur_new - cur_old) : (cur_old - cur_new);
    run_max_next = (diff > run_max_q) ? diff : run_max_q;
    iter_next    = iter_count + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      shadow_alpha_q <= '0;
      shadow_act_q   <= '0;
      shadow_eps_q   <= '0;
      run_max_q      <= '0;
      idx_q          <= '0;
      prev_valid_q   <= 1'b0;
      alpha_prev     <= '0;
      policy         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      next_en        <= 1'b0;
      converged      <= 1'b0;
      timeout        <= 1'b0;
      max_diff       <= '0;
      iter_count     <= '0;
    end else begin
      done    <= 1'b0;
      next_en <= 1'b0;
      if (clear) begin
        // Committed vectors, policy and max_diff survive a clear on purpose.
        state_q      <= StIdle;
        prev_valid_q <= 1'b0;
        iter_count   <= '0;
        converged    <= 1'b0;
        timeout      <= 1'b0;
        busy         <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              shadow_alpha_q <= alpha_in;
              shadow_act_q   <= action_in;
              shadow_eps_q   <= eps;
              idx_q          <= '0;
              run_max_q      <= '0;
              busy           <= 1'b1;
              state_q        <= StScan;
            end
          end
          StScan: begin
            run_max_q <= run_max_next;
            idx_q     <= idx_q + IdxW'(1);
            if (idx_q == LastIdx) state_q <= StDecide;
          end
          StDecide: begin
            alpha_prev   <= shadow_alpha_q;
            policy       <= shadow_act_q;
            max_diff     <= run_max_q;
            iter_count   <= iter_next;
            busy         <= 1'b0;
            done         <= 1'b1;
            prev_valid_q <= 1'b1;
            // Convergence wins over the cap when both hold on the same iteration.
            if (prev_valid_q && (run_max_q <= shadow_eps_q)) begin
              converged <= 1'b1;
              state_q   <= StHalt;
            end else if (iter_next == MaxIter) begin
              timeout <= 1'b1;
              state_q <= StHalt;
            end else begin
              next_en <= 1'b1;
              state_q <= StIdle;
            end
          end
          StHalt: begin
            state_q <= StHalt;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pbvi_converge_check.sv
// Scoreboard bench for pbvi_converge_check (built with MAX_ITER=4 so the cap is reachable).
module tb_pbvi_converge_check;

  localparam int NP   = 16;
  localparam int NS   = 2;
  localparam int W    = 16;
  localparam int NE   = NP * NS;
  localparam int AW   = NP * NS * W;
  localparam int MAXI = 4;
  localparam int IW   = 8;
  localparam int LAT  = 33;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic [W-1:0]    eps = '0;
  logic [AW-1:0]   alpha_in = '0;
  logic [2*NP-1:0] action_in = '0;
  logic [AW-1:0]   alpha_prev;
  logic [2*NP-1:0] policy;
  logic            busy, done, next_en, converged, timeout;
  logic [W-1:0]    max_diff;
  logic [IW-1:0]   iter_count;

  pbvi_converge_check #(
    .N_POINTS(NP), .N_STATES(NS), .W(W), .MAX_ITER(MAXI), .IW(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .eps(eps),
    .alpha_in(alpha_in), .action_in(action_in), .alpha_prev(alpha_prev),
    .policy(policy), .busy(busy), .done(done), .next_en(next_en),
    .converged(converged), .timeout(timeout), .max_diff(max_diff),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]   alpha;
    logic [2*NP-1:0] pol;
    logic [W-1:0]    md;
    logic            conv;
    logic            to;
    logic            ne;
    logic [IW-1:0]   iter;
    int              start_cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;

  // Reference state of the loop, derived from the behavioural description.
  logic [AW-1:0] m_prev = '0;
  logic          m_valid = 1'b0;
  int            m_iter = 0;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] fill(input logic [W-1:0] v);
    logic [AW-1:0] a;
    for (int i = 0; i < NE; i++) a[i*W +: W] = v;
    return a;
  endfunction

  // Output monitor: every done pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    check("next_en_implies_done", AW'(next_en & ~done), AW'(0));
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", AW'(1), AW'(0));
      end else begin
        e = sb.pop_front();
        check("latency", AW'(cyc - e.start_cyc), AW'(LAT));
        check("max_diff", AW'(max_diff), AW'(e.md));
        check("converged", AW'(converged), AW'(e.conv));
        check("timeout", AW'(timeout), AW'(e.to));
        check("next_en", AW'(next_en), AW'(e.ne));
        check("iter_count", AW'(iter_count), AW'(e.iter));
        check("busy_at_done", AW'(busy), AW'(0));
        check("policy", AW'(policy), AW'(e.pol));
        check("alpha_prev", alpha_prev, e.alpha);
      end
    end
  end

  // One full iteration; poke>0 re-pulses start that many cycles into the scan.
  task automatic do_iter(input logic [AW-1:0] a, input logic [2*NP-1:0] act,
                         input logic [W-1:0] e, input int poke);
    exp_t x;
    logic [W-1:0] dmax, nv, ov, dv;
    int target;
    dmax = '0;
    for (int i = 0; i < NE; i++) begin
      nv = a[i*W +: W];
      ov = m_prev[i*W +: W];
      dv = (nv > ov) ? nv - ov : ov - nv;
      if (dv > dmax) dmax = dv;
    end
    m_iter++;
    x.conv  = m_valid && (dmax <= e);
    x.to    = !x.conv && (m_iter == MAXI);
    x.ne    = !x.conv && !x.to;
    x.md    = dmax;
    x.iter  = IW'(m_iter);
    x.alpha = a;
    x.pol   = act;
    m_prev  = a;
    m_valid = 1'b1;
    target  = n_done + 1;
    alpha_in  = a;
    action_in = act;
    eps       = e;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x.start_cyc = cyc;
    sb.push_back(x);
    #1;
    check("busy_scan", AW'(busy), AW'(1));
    // Inputs change after the snapshot; results must not follow them.
    alpha_in = ~a;
    eps      = ~e;
    for (int k = 1; k < LAT + 10 && n_done < target; k++) begin
      start = (poke > 0 && k == poke);
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    if (n_done < target) begin
      check("done_wait", AW'(0), AW'(1));
      sb.delete();
    end
    @(negedge clk);
    #1;
    check("done_one_cycle", AW'({done, next_en}), AW'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_prev  = '0;
    m_valid = 1'b0;
    m_iter  = 0;
    sb.delete();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_valid = 1'b0;
    m_iter  = 0;
  endtask

  logic [AW-1:0]   a100, amod;
  logic [2*NP-1:0] act1, act2;

  initial begin
    a100 = fill(16'd100);
    amod = a100;
    amod[(7*NS+1)*W +: W] = 16'd105;
    amod[(3*NS+0)*W +: W] = 16'd98;
    act1 = 32'h5555_5555;
    act2 = 32'h1B1B_E4E4;

    // 1: reset and idle
    do_reset();
    repeat (5) @(negedge clk);
    check("rst_busy", AW'(busy), AW'(0));
    check("rst_flags", AW'({done, next_en, converged, timeout}), AW'(0));
    check("rst_max_diff", AW'(max_diff), AW'(0));
    check("rst_iter", AW'(iter_count), AW'(0));
    check("rst_policy", AW'(policy), AW'(0));
    check("rst_alpha_prev", alpha_prev, AW'(0));

    // 2, 3: first iteration never converges; identical second one does
    do_iter(a100, act1, 16'd0, 0);
    do_iter(a100, act1, 16'd0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    check("halt_ignores_start", AW'(busy), AW'(0));
    check("halt_iter", AW'(iter_count), AW'(2));
    check("halt_converged", AW'(converged), AW'(1));

    // 4: max_diff = 5 against threshold 4 then 5
    do_clear();
    do_iter(a100, act1, 16'd0, 0);
    do_iter(amod, act2, 16'd4, 0);
    do_clear();
    do_iter(a100, act1, 16'd0, 0);
    do_iter(amod, act2, 16'd5, 0);

    // 5: alternating sets run into the iteration cap
    do_clear();
    check("clear_flags", AW'({converged, timeout, busy}), AW'(0));
    check("clear_keeps_max_diff", AW'(max_diff), AW'(5));
    for (int i = 0; i < MAXI; i++) do_iter(fill((i % 2) ? 16'd1000 : 16'd0), act1, 16'd0, 0);
    repeat (3) @(negedge clk);
    check("timeout_sticky", AW'({timeout, converged}), AW'(2'b10));

    // 6a: reset in the middle of a scan
    do_clear();
    alpha_in = fill(16'd77);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("abort_iter", AW'(iter_count), AW'(0));
    check("abort_alpha_prev", alpha_prev, AW'(0));
    check("abort_busy", AW'(busy), AW'(0));
    do_iter(a100, act1, 16'hFFFF, 0);
    // 6b: start pulsed mid-scan leaves timing alone
    do_iter(fill(16'd200), act2, 16'd0, 10);
    // 6c: clear mid-scan drops the iteration without committing
    alpha_in = fill(16'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_valid = 1'b0;
    m_iter  = 0;
    #1;
    check("clear_scan_busy", AW'(busy), AW'(0));
    check("clear_scan_iter", AW'(iter_count), AW'(0));
    repeat (LAT + 5) @(negedge clk);
    do_iter(fill(16'd200), act1, 16'd0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", AW'(sb.size()), AW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
